// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder (slave end of the CPU
// load/store port). One outstanding request, fixed latency, big-endian byte
// order (most significant byte at the lowest address).
//
// Optional feature macro: DMEM_ERR_CHECK_EN
//   defined   -> illegal size, misaligned or out-of-range requests return
//                resp_err=1 with no array write and zero read data
//   undefined -> addresses wrap modulo DEPTH_BYTES, illegal sizes act as 8,
//                resp_err is constantly 0

module dmem_responder #(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned LATENCY     = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [3:0]  req_size,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH_BYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            write_q, write_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [63:0]     wdata_q, wdata_d;
   logic [3:0]      size_q, size_d;
   logic            err_q, err_d;
   logic [63:0]     rdata_q, rdata_d;
   logic            rerr_q, rerr_d;

   logic [7:0]      mem_q [DEPTH_BYTES];
   logic            mem_we;

   logic            size_ok;
   logic [3:0]      size_norm;
   logic            req_err;
   logic [AW-1:0]   byte_idx [8];
   logic [63:0]     load_data;

   // Decode the incoming request: normalise size and evaluate error checks
   always_comb begin
      size_ok   = (req_size == 4'd1) || (req_size == 4'd2) ||
                  (req_size == 4'd4) || (req_size == 4'd8);
      size_norm = size_ok ? req_size : 4'd8;
   end

`ifdef DMEM_ERR_CHECK_EN
   // Flag illegal size, misalignment and out-of-range on the full address
   always_comb begin
      req_err = !size_ok ||
                ((req_addr & (64'(size_norm) - 64'd1)) != '0) ||
                (({1'b0, req_addr} + 65'(size_norm)) > 65'(DEPTH_BYTES));
   end
`else
   logic unused_addr_hi;
   assign unused_addr_hi = ^{req_addr[63:AW], size_ok};
   assign req_err        = 1'b0;
`endif

   // Byte i (counted from the LSB of the data word) lives at addr+size-1-i;
   // modular AW-bit arithmetic gives the wrap-around for free
   always_comb begin
      for (int unsigned i = 0; i < 8; i++) begin
         byte_idx[i] = addr_q + AW'(size_q) - AW'(1) - AW'(i);
      end
   end

   // Assemble right-justified, zero-extended load data from the array
   always_comb begin
      load_data = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < 32'(size_q)) begin
            load_data[8*i +: 8] = mem_q[byte_idx[i]];
         end
      end
   end

   // Next-state, request capture and response generation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      rerr_d  = rerr_q;
      mem_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr[AW-1:0];
               wdata_d = req_wdata;
               size_d  = size_norm;
               err_d   = req_err;
               cnt_d   = 4'(LATENCY - 1);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               if (err_q) begin
                  rdata_d = '0;
                  rerr_d  = 1'b1;
               end else begin
                  rdata_d = write_q ? 64'd0 : load_data;
                  rerr_d  = 1'b0;
                  mem_we  = write_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) begin
               state_d = S_IDLE;
               rdata_d = '0;
               rerr_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and captured-request registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= 4'd1;
         err_q   <= 1'b0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
      end
   end

   // Storage array: not reset; a reset on the commit edge cancels the store
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(size_q)) begin
               mem_q[byte_idx[i]] <= wdata_q[8*i +: 8];
            end
         end
      end
   end

   assign req_ready  = (state_q == S_IDLE) && !reset;
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder (LATENCY=3, 1 KiB).
// Builds with or without DMEM_ERR_CHECK_EN; the feature-specific sequences
// follow the same macro.

module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int          LAT   = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_size;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic        w;
      logic [63:0] a;
      logic [63:0] d;
      logic [3:0]  s;
      logic [63:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t tbl [9];

   dmem_responder #(
      .DEPTH_BYTES (DEPTH),
      .LATENCY     (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_size   (req_size),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Wait (bounded) for req_ready, then present a request for one edge
   task automatic start_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                            input logic [3:0] s);
      int k;
      @(negedge clk);
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("req_ready_idle", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_size  = s;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      // scramble fields: they must have been captured at acceptance
      req_write = ~w;
      req_addr  = ~a;
      req_wdata = ~d;
      req_size  = 4'd2;
   endtask

   // Count edges after acceptance until resp_valid; 0 means timed out
   task automatic wait_resp(output int lat);
      lat = 0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         if (resp_valid) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic finish_resp();
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check("ready_after_hs", {63'd0, req_ready}, 64'd1);
      check("valid_after_hs", {63'd0, resp_valid}, 64'd0);
   endtask

   task automatic txn(input string nm, input logic w, input logic [63:0] a,
                      input logic [63:0] d, input logic [3:0] s,
                      input logic [63:0] exp_rdata, input logic exp_err);
      int lat;
      start_req(w, a, d, s);
      wait_resp(lat);
      check({nm, "_latency"}, 64'(lat), 64'(LAT));
      check({nm, "_rdata"}, resp_rdata, exp_rdata);
      check({nm, "_err"}, {63'd0, resp_err}, {63'd0, exp_err});
      finish_resp();
   endtask

   initial begin
      int lat;
      logic [63:0] held;

      tbl[0] = '{1'b1, 64'h08, 64'h0123456789ABCDEF, 4'd8, 64'h0, 1'b0};
      tbl[1] = '{1'b0, 64'h08, 64'h0, 4'd8, 64'h0123456789ABCDEF, 1'b0};
      tbl[2] = '{1'b0, 64'h08, 64'h0, 4'd1, 64'h01, 1'b0};
      tbl[3] = '{1'b0, 64'h0E, 64'h0, 4'd2, 64'hCDEF, 1'b0};
      tbl[4] = '{1'b0, 64'h0C, 64'h0, 4'd4, 64'h89ABCDEF, 1'b0};
      tbl[5] = '{1'b1, 64'h20, 64'hFFFF_FFFF_FFFF_BEEF, 4'd2, 64'h0, 1'b0};
      tbl[6] = '{1'b0, 64'h20, 64'h0, 4'd2, 64'hBEEF, 1'b0};
      tbl[7] = '{1'b0, 64'h21, 64'h0, 4'd1, 64'hEF, 1'b0};
      tbl[8] = '{1'b1, 64'h30, 64'h11223344, 4'd4, 64'h0, 1'b0};

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_size   = 4'd1;
      resp_ready = 1'b0;

      // reset for two cycles
      @(posedge clk);
      @(negedge clk);
      check("rst_req_ready_low", {63'd0, req_ready}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);
      check("post_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("post_rst_resp_err", {63'd0, resp_err}, 64'd0);
      check("post_rst_resp_rdata", resp_rdata, 64'd0);

      // table-driven main function
      for (int i = 0; i < 9; i++) begin
         txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s,
             tbl[i].exp_rdata, tbl[i].exp_err);
      end
      txn("ld_0x32_s2", 1'b0, 64'h32, 64'h0, 4'd2, 64'h3344, 1'b0);

      // reset in WAIT aborts a pending store to 0x10
      txn("st_0x10_old", 1'b1, 64'h10, 64'h1111_2222_3333_4444, 4'd8, 64'h0, 1'b0);
      start_req(1'b1, 64'h10, 64'hAAAA_BBBB_CCCC_DDDD, 4'd8);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("wait_rst_req_ready", {63'd0, req_ready}, 64'd0);
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("abort_no_resp", {63'd0, resp_valid}, 64'd0);
      end
      txn("ld_0x10_old", 1'b0, 64'h10, 64'h0, 4'd8, 64'h1111_2222_3333_4444, 1'b0);

      // response held for 5 cycles; a req_valid pulse must be ignored
      start_req(1'b0, 64'h08, 64'h0, 4'd8);
      wait_resp(lat);
      check("hold_latency", 64'(lat), 64'(LAT));
      held = resp_rdata;
      check("hold_rdata_first", held, 64'h0123456789ABCDEF);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = (c == 2);
         req_write = 1'b1;
         req_addr  = 64'h08;
         req_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
         req_size  = 4'd8;
         check("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
         check("hold_resp_rdata", resp_rdata, held);
         check("hold_req_ready", {63'd0, req_ready}, 64'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      finish_resp();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("no_queued_resp", {63'd0, resp_valid}, 64'd0);
      end
      txn("ld_0x08_intact", 1'b0, 64'h08, 64'h0, 4'd8, 64'h0123456789ABCDEF, 1'b0);

`ifdef DMEM_ERR_CHECK_EN
      txn("st_0x00_base", 1'b1, 64'h00, 64'hCAFEF00D_12345678, 4'd8, 64'h0, 1'b0);
      txn("st_misaligned", 1'b1, 64'h03, 64'hDEADBEEF, 4'd4, 64'h0, 1'b1);
      txn("ld_0x00_unchanged", 1'b0, 64'h00, 64'h0, 4'd8, 64'hCAFEF00D_12345678, 1'b0);
      txn("ld_size3", 1'b0, 64'h08, 64'h0, 4'd3, 64'h0, 1'b1);
      txn("ld_misaligned_rd0", 1'b0, 64'h09, 64'h0, 4'd2, 64'h0, 1'b1);
      txn("ld_out_of_range", 1'b0, 64'h400, 64'h0, 4'd1, 64'h0, 1'b1);
      txn("ld_high_addr", 1'b0, 64'hFFFF_FFFF_0000_0408, 64'h0, 4'd1, 64'h0, 1'b1);
      txn("ld_last_byte", 1'b0, 64'h3FF, 64'h0, 4'd1, 64'h0, 1'b0);
`else
      txn("st_wrap", 1'b1, 64'(DEPTH - 4), 64'h0123456789ABCDEF, 4'd8, 64'h0, 1'b0);
      txn("ld_wrap_lo", 1'b0, 64'h00, 64'h0, 4'd4, 64'h89ABCDEF, 1'b0);
      txn("ld_wrap_hi", 1'b0, 64'(DEPTH - 4), 64'h0, 4'd4, 64'h01234567, 1'b0);
      txn("st_size3_as8", 1'b1, 64'h40, 64'hA1A2A3A4A5A6A7A8, 4'd3, 64'h0, 1'b0);
      txn("ld_0x40_s8", 1'b0, 64'h40, 64'h0, 4'd8, 64'hA1A2A3A4A5A6A7A8, 1'b0);
      txn("ld_0x41_s1", 1'b0, 64'h41, 64'h0, 4'd1, 64'hA2, 1'b0);
      txn("ld_high_addr", 1'b0, 64'hFFFF_FFFF_0000_0408, 64'h0, 4'd1, 64'h01, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
